// File: rtl/rr_tone_meter.sv
// Tone-period meter for the RickRoll player output: recovers the square-wave
// period in clock cycles and flags lock and silence.
module rr_tone_meter #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned MIN_PERIOD = 4,
  parameter int unsigned TOL        = 2,
  parameter int unsigned STABLE_N   = 2,
  parameter int unsigned TIMEOUT    = 1000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tone_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             silent
);

  localparam int unsigned MW = $clog2(STABLE_N + 1);

  typedef enum logic {S_IDLE, S_MEASURE} state_t;

  state_t           r_state;
  logic             r_sync1, r_sync2, r_sync3;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_last_sample;
  logic             r_has_sample;
  logic [MW-1:0]    r_match_cnt;

  logic             w_rise;
  logic             w_timeout;
  logic [CNT_W-1:0] w_sample;
  logic             w_glitch;
  logic [CNT_W-1:0] w_diff_last;
  logic [CNT_W-1:0] w_diff_period;
  logic             w_near_last;
  logic             w_near_period;
  logic [MW-1:0]    w_match_next;
  logic             w_publish;

  function automatic logic [CNT_W-1:0] abs_diff(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  assign w_rise        = r_sync2 & ~r_sync3;
  assign w_timeout     = (r_cnt == CNT_W'(TIMEOUT));
  // cnt < TIMEOUT whenever a sample is taken, so cnt+1 cannot wrap
  assign w_sample      = r_cnt + CNT_W'(1);
  assign w_glitch      = (w_sample < CNT_W'(MIN_PERIOD));
  assign w_diff_last   = abs_diff(w_sample, r_last_sample);
  assign w_diff_period = abs_diff(w_sample, period);
  assign w_near_last   = (w_diff_last <= CNT_W'(TOL));
  assign w_near_period = (w_diff_period <= CNT_W'(TOL));

  always_comb begin
    w_match_next = '0;
    if (r_has_sample && w_near_last) begin
      if (r_match_cnt == MW'(STABLE_N)) w_match_next = r_match_cnt;
      else                              w_match_next = r_match_cnt + MW'(1);
    end
  end

  assign w_publish = (w_match_next == MW'(STABLE_N)) && (!locked || !w_near_period);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_sync1       <= 1'b0;
      r_sync2       <= 1'b0;
      r_sync3       <= 1'b0;
      r_cnt         <= '0;
      r_last_sample <= '0;
      r_has_sample  <= 1'b0;
      r_match_cnt   <= '0;
      period        <= '0;
      period_valid  <= 1'b0;
      locked        <= 1'b0;
      silent        <= 1'b1;
    end else begin
      r_sync1      <= tone_in;
      r_sync2      <= r_sync1;
      r_sync3      <= r_sync2;
      period_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_rise) begin
            r_state <= S_MEASURE;
            r_cnt   <= '0;
          end
        end
        S_MEASURE: begin
          // timeout is checked first so a coincident edge is dropped
          if (w_timeout) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_last_sample <= '0;
            r_has_sample  <= 1'b0;
            r_match_cnt   <= '0;
            period        <= '0;
            locked        <= 1'b0;
            silent        <= 1'b1;
          end else if (w_rise && !w_glitch) begin
            r_cnt         <= '0;
            r_match_cnt   <= w_match_next;
            r_last_sample <= w_sample;
            r_has_sample  <= 1'b1;
            if (w_publish) begin
              period       <= w_sample;
              period_valid <= 1'b1;
              locked       <= 1'b1;
              silent       <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_tone_meter.sv
// Bench for rr_tone_meter: expected periods are queued ahead of the edge that
// should publish them and matched against each period_valid pulse.
module tb_rr_tone_meter;

  logic        clock   = 1'b0;
  logic        reset   = 1'b1;
  logic        tone_in = 1'b0;
  logic [15:0] period;
  logic        period_valid;
  logic        locked;
  logic        silent;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int          exp_q[$];
  logic        prev_pv  = 1'b0;

  always #5 clock = ~clock;

  rr_tone_meter #(
    .CNT_W      (16),
    .MIN_PERIOD (4),
    .TOL        (2),
    .STABLE_N   (2),
    .TIMEOUT    (1000)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .tone_in      (tone_in),
    .period       (period),
    .period_valid (period_valid),
    .locked       (locked),
    .silent       (silent)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every pulse must match the oldest queued period.
  always @(negedge clock) begin
    if (period_valid === 1'b1) begin
      check("pv_single_cycle", prev_pv, 0);
      if (exp_q.size() == 0) check("unexpected_pv", 1, 0);
      else                   check("pv_period", period, exp_q.pop_front());
    end
    prev_pv = period_valid;
  end

  // Called at a negedge; rising edge now, falling edge after hi cycles.
  task automatic tone(input int hi, input int lo);
    tone_in = 1'b1;
    repeat (hi) @(negedge clock);
    tone_in = 1'b0;
    repeat (lo) @(negedge clock);
  endtask

  // Rises at 0 and 3 (a sub-MIN_PERIOD interval), 110 cycles in total.
  task automatic glitch_110();
    tone_in = 1'b1;
    @(negedge clock);
    tone_in = 1'b0;
    repeat (2) @(negedge clock);
    tone_in = 1'b1;
    repeat (52) @(negedge clock);
    tone_in = 1'b0;
    repeat (55) @(negedge clock);
  endtask

  initial begin
    #1 reset = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_period", period, 0);
    check("rst_pv", period_valid, 0);
    check("rst_locked", locked, 0);
    check("rst_silent", silent, 1);
    reset = 1'b1;
    repeat (3) @(negedge clock);

    // Steady 100: start edge + 3 samples, publish on the 4th rise.
    repeat (3) tone(50, 50);
    check("t2_prelock", locked, 0);
    exp_q.push_back(100);
    repeat (21) tone(50, 50);
    check("t2_locked", locked, 1);
    check("t2_period", period, 100);
    check("t2_silent", silent, 0);

    // Note change: samples 100, 150, 150, then the third 150 publishes.
    repeat (3) tone(75, 75);
    check("t4_hold_period", period, 100);
    check("t4_hold_locked", locked, 1);
    exp_q.push_back(150);
    repeat (4) tone(75, 75);
    check("t4_new_period", period, 150);

    // Glitch during buildup to 110: samples 150, 110, (glitch), 110, 110.
    tone(55, 55);
    glitch_110();
    tone(55, 55);
    check("t5_hold_period", period, 150);
    exp_q.push_back(110);
    tone(55, 55);
    check("t5_new_period", period, 110);
    repeat (3) tone(55, 55);
    check("t5_locked", locked, 1);

    // Asynchronous reset mid-count with the tone still toggling.
    tone_in = 1'b1;
    repeat (30) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("t1_async_period", period, 0);
    check("t1_async_pv", period_valid, 0);
    check("t1_async_locked", locked, 0);
    check("t1_async_silent", silent, 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      tone_in = ~tone_in;
    end
    check("t1_hold_locked", locked, 0);
    tone_in = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    repeat (5) @(negedge clock);

    // Jitter from scratch: samples 100, 99, 101 -> publish 101 on 4th rise.
    tone(50, 50);
    tone(50, 49);
    tone(50, 51);
    check("t3_prelock", locked, 0);
    exp_q.push_back(101);
    tone(50, 50);
    repeat (4) begin
      tone(50, 49);
      tone(50, 51);
      tone(50, 50);
    end
    check("t3_period", period, 101);
    check("t3_locked", locked, 1);

    // Silence: last rise sampled at posedge 0, processed at posedge 2 (cnt=0),
    // cnt=1000 after posedge 1002, timeout applied at posedge 1003.
    tone_in = 1'b1;
    for (int i = 1; i <= 1004; i++) begin
      @(negedge clock);
      if (i == 50) tone_in = 1'b0;
      if (i == 1003) begin
        check("t6_pre_silent", silent, 0);
        check("t6_pre_locked", locked, 1);
      end
    end
    check("t6_silent", silent, 1);
    check("t6_locked", locked, 0);
    check("t6_period", period, 0);

    // Timeout tie: start edge at posedge 0; the rise sampled at posedge 1001
    // lands in the cycle where cnt==1000 and must be dropped.
    tone_in = 1'b1;
    for (int i = 1; i <= 1001; i++) begin
      @(negedge clock);
      if (i == 50) tone_in = 1'b0;
      if (i == 1001) tone_in = 1'b1;
    end
    repeat (50) @(negedge clock);
    tone_in = 1'b0;
    repeat (50) @(negedge clock);
    repeat (3) tone(50, 50);
    check("t6_tie_unlocked", locked, 0);
    check("t6_tie_silent", silent, 1);
    exp_q.push_back(100);
    repeat (2) tone(50, 50);
    check("t6_tie_locked", locked, 1);
    check("t6_tie_period", period, 100);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
